pc_fetch_ctrl: RTL and testbench

Program-counter register and fetch-request sequencer that sits directly upstream of the combinational ADDER stage. It drives the ADDER operands (current PC and the increment constant) and registers the ADDER sum as the next sequential PC. It also issues instruction-memory requests over a req/ack handshake, and applies stalls, branch redirects, alignment checks and an acknowledge timeout.

---
 rtl/pc_fetch_ctrl_if.sv | 20 ++
 rtl/pc_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between the PC sequencer and the memory.
interface pc_fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer feeding the ADDER stage; handles stalls,
// redirects, alignment faults and the fetch acknowledge timeout.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INCR     = 32'd4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            add_a_o,
  output logic [31:0]            add_b_o,
  input  logic [31:0]            add_sum_i,
  input  logic                   stall_i,
  input  logic                   br_valid_i,
  input  logic [31:0]            br_target_i,
  output logic                   kill_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_PRE = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             kill_q, kill_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             tmo_hit;

  logic br_ok, br_bad;
  assign br_ok  = br_valid_i && (br_target_i[1:0] == 2'b00);
  assign br_bad = br_valid_i && (br_target_i[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (imem.imem_ack_i && stall_i) state_d = S_HOLD;
      S_HOLD:  if (!stall_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    kill_d     = 1'b0;
    tmo_hit    = 1'b0;
    req_d      = (state_d == S_REQ);
    err_d      = err_q;
    code_d     = code_q;

    case (state_q)
      S_REQ: begin
        if (imem.imem_ack_i) begin
          // A redirect seen during this fetch makes the acked word wrong-path.
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          kill_d     = br_ok || pend_vld_q;
          if (br_ok)           pc_d = br_target_i;
          else if (pend_vld_q) pc_d = pend_q;
          else                 pc_d = add_sum_i;
        end else begin
          if (br_ok) begin
            pend_vld_d = 1'b1;
            pend_d     = br_target_i;
          end
          if (cnt_q != TMO_MAX) cnt_d = CNT_W'(cnt_q + 1'b1);
          tmo_hit = (cnt_q == TMO_PRE);
        end
      end
      default: begin
        // No fetch outstanding: redirects apply directly.
        pend_vld_d = 1'b0;
        if (br_ok) pc_d = br_target_i;
      end
    endcase

    if (!err_q && (br_bad || tmo_hit)) begin
      err_d  = 1'b1;
      code_d = {tmo_hit, br_bad};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign add_a_o          = pc_q;
  assign add_b_o          = INCR;
  assign kill_o           = kill_q;
  assign err_o            = err_q;
  assign err_code_o       = code_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_pc_fetch_ctrl;

  localparam int unsigned TMO   = 16;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n_w = 1'b0;
  logic        stall, ack, bv;
  logic [31:0] bt, sum_fault;

  logic [31:0] add_a, add_b, add_sum;
  logic        kill, err;
  logic [1:0]  code;
  logic [31:0] add_a_w, add_b_w, add_sum_w;
  logic        kill_w, err_w;
  logic [1:0]  code_w;

  pc_fetch_ctrl_if bus();
  pc_fetch_ctrl_if bus_w();

  assign bus.imem_ack_i   = ack;
  assign bus_w.imem_ack_i = ack;
  assign add_sum   = add_a + add_b + sum_fault;
  assign add_sum_w = add_a_w + add_b_w;

  pc_fetch_ctrl #(.RESET_PC(RST_A), .INCR(32'd4), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .add_a_o(add_a), .add_b_o(add_b), .add_sum_i(add_sum),
    .stall_i(stall), .br_valid_i(bv), .br_target_i(bt),
    .kill_o(kill), .err_o(err), .err_code_o(code)
  );

  pc_fetch_ctrl #(.RESET_PC(RST_W), .INCR(32'd4), .TIMEOUT(TMO)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .imem(bus_w),
    .add_a_o(add_a_w), .add_b_o(add_b_w), .add_sum_i(add_sum_w),
    .stall_i(stall), .br_valid_i(bv), .br_target_i(bt),
    .kill_o(kill_w), .err_o(err_w), .err_code_o(code_w)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic [31:0] a,
                         input logic k, input logic e, input logic [1:0] c);
    chk({tag, ".req"},   32'(bus.imem_req_o), 32'(r));
    chk({tag, ".addr"},  bus.imem_addr_o, a);
    chk({tag, ".kill"},  32'(kill), 32'(k));
    chk({tag, ".err"},   32'(err), 32'(e));
    chk({tag, ".code"},  32'(code), 32'(c));
  endtask

  task automatic set_in(input logic s, input logic a, input logic v,
                        input logic [31:0] t, input logic [31:0] f);
    stall = s; ack = a; bv = v; bt = t; sum_fault = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: a fetch is either outstanding or not,
  // plus the latest redirect remembered while waiting.
  logic [31:0] m_pc, m_pend_t;
  logic        m_req, m_boot, m_pend_v, m_kill, m_err;
  logic [1:0]  m_code;
  int          m_wait;

  task automatic model_reset();
    m_pc = RST_A; m_req = 1'b0; m_boot = 1'b1; m_pend_v = 1'b0; m_pend_t = '0;
    m_kill = 1'b0; m_err = 1'b0; m_code = 2'b00; m_wait = 0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic v,
                            input logic [31:0] t, input logic [31:0] f);
    logic good, bad, tmo;
    good = v && (t[1:0] == 2'b00);
    bad  = v && !good;
    tmo  = 1'b0;
    m_kill = 1'b0;
    if (m_req) begin
      if (a) begin
        m_kill = good || m_pend_v;
        if (good)          m_pc = t;
        else if (m_pend_v) m_pc = m_pend_t;
        else               m_pc = m_pc + 32'd4 + f;
        m_pend_v = 1'b0;
        m_wait   = 0;
        m_req    = !s;
      end else begin
        if (good) begin m_pend_v = 1'b1; m_pend_t = t; end
        if (m_wait < int'(TMO)) begin
          m_wait++;
          tmo = (m_wait == int'(TMO));
        end
      end
    end else begin
      if (good) m_pc = t;
      m_req  = m_boot || !s;
      m_boot = 1'b0;
    end
    if (!m_err && (bad || tmo)) begin
      m_err  = 1'b1;
      m_code = {tmo, bad};
    end
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic        stall;
    logic        ack;
    logic        bv;
    logic [31:0] bt;
    logic        req;
    logic [31:0] addr;
    logic        kill;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  function automatic vec_t mkv(input logic s, input logic a, input logic v, input logic [31:0] t,
                               input logic r, input logic [31:0] ad, input logic k,
                               input logic e, input logic [1:0] c);
    vec_t x;
    x.stall = s; x.ack = a; x.bv = v; x.bt = t;
    x.req = r; x.addr = ad; x.kill = k; x.err = e; x.code = c;
    return x;
  endfunction

  vec_t tbl [15];

  initial begin
    int drought;
    logic s, a, v;
    logic [31:0] t, f;

    //            stall ack bv  target        req addr          kill err code
    tbl[0]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h000, 1'b0, 1'b0, 2'b00);
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h004, 1'b0, 1'b0, 2'b00);
    tbl[2]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h008, 1'b0, 1'b0, 2'b00);
    tbl[3]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h00C, 1'b0, 1'b0, 2'b00);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b1, 32'h100,   1'b1, 32'h00C, 1'b0, 1'b0, 2'b00);
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h00C, 1'b0, 1'b0, 2'b00);
    tbl[6]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h100, 1'b1, 1'b0, 2'b00);
    tbl[7]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h104, 1'b0, 1'b0, 2'b00);
    tbl[8]  = mkv(1'b0, 1'b1, 1'b1, 32'h200,   1'b1, 32'h200, 1'b1, 1'b0, 2'b00);
    tbl[9]  = mkv(1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h204, 1'b0, 1'b0, 2'b00);
    tbl[10] = mkv(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h204, 1'b0, 1'b0, 2'b00);
    tbl[11] = mkv(1'b1, 1'b0, 1'b1, 32'h300,   1'b0, 32'h300, 1'b0, 1'b0, 2'b00);
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h300, 1'b0, 1'b0, 2'b00);
    tbl[13] = mkv(1'b0, 1'b1, 1'b1, 32'h102,   1'b1, 32'h304, 1'b0, 1'b1, 2'b01);
    tbl[14] = mkv(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h308, 1'b0, 1'b1, 2'b01);

    // Vector table: sequential fetch, pending and same-cycle redirects,
    // stall/hold redirect, misaligned target.
    do_reset();
    chk_all("reset", 1'b0, RST_A, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].stall, tbl[i].ack, tbl[i].bv, tbl[i].bt, 32'h0);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].kill, tbl[i].err, tbl[i].code);
      chk($sformatf("vec%0d.add_a", i), add_a, tbl[i].addr);
      chk($sformatf("vec%0d.add_b", i), add_b, 32'd4);
    end

    // Stall with ack in the first stall cycle, then ack timeout.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (9) step();
    chk_all("pre_stall", 1'b1, 32'h20, 1'b0, 1'b0, 2'b00);
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("stall0", 1'b0, 32'h24, 1'b0, 1'b0, 2'b00);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 1'b0, 32'h24, 1'b0, 1'b0, 2'b00);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("unstall", 1'b1, 32'h24, 1'b0, 1'b0, 2'b00);
    for (int k = 1; k <= int'(TMO); k++) begin
      step();
      chk_all($sformatf("tmo%0d", k), 1'b1, 32'h24, 1'b0, k == int'(TMO),
              (k == int'(TMO)) ? 2'b10 : 2'b00);
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("late_ack", 1'b1, 32'h28, 1'b0, 1'b1, 2'b10);

    // Randomized traffic against the model, including adder faults.
    do_reset();
    chk_all("rnd_reset", 1'b0, RST_A, 1'b0, 1'b0, 2'b00);
    drought = 0;
    for (int c = 0; c < 800; c++) begin
      s = ($urandom_range(0, 4) == 0);
      a = ($urandom_range(0, 2) != 0);
      if (drought > 0) begin a = 1'b0; drought--; end
      else if ($urandom_range(0, 60) == 0) drought = 20;
      v = ($urandom_range(0, 7) == 0);
      t = $urandom();
      t[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      f = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'h0000_0FF0) : 32'h0;
      model_step(s, a, v, t, f);
      set_in(s, a, v, t, f);
      step();
      chk_all($sformatf("rnd%0d", c), m_req, m_pc, m_kill, m_err, m_code);
      if (c % 50 == 0) begin
        do_reset();
        chk_all($sformatf("rnd_rst%0d", c), 1'b0, RST_A, 1'b0, 1'b0, 2'b00);
      end
    end

    // Wrap at the top of the address space, then async reset mid-request.
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n_w = 1'b1;
    chk("wrap.reset_req", 32'(bus_w.imem_req_o), 32'd0);
    chk("wrap.reset_addr", bus_w.imem_addr_o, RST_W);
    step();
    chk("wrap.req0", 32'(bus_w.imem_req_o), 32'd1);
    chk("wrap.addr0", bus_w.imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("wrap.addr1", bus_w.imem_addr_o, 32'h0000_0000);
    step();
    chk("wrap.addr2", bus_w.imem_addr_o, 32'h0000_0004);
    chk("wrap.err", 32'(err_w), 32'd0);
    chk("wrap.kill", 32'(kill_w), 32'd0);
    #2 rst_n_w = 1'b0;
    #1;
    chk("wrap.async_req", 32'(bus_w.imem_req_o), 32'd0);
    chk("wrap.async_addr", bus_w.imem_addr_o, RST_W);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
